chime_scheduler: RTL and testbench

CHIME_SCHEDULER -- requirements
Module: chime_scheduler

---
 rtl/chime_scheduler.sv | 178 +++++++++++++++++
 tb/tb_chime_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/chime_scheduler.sv
// chime_scheduler
// Buzzer scheduler for a 12-hour clock. It arbitrates three beep sources:
// alarm (highest), hourly chime, and key-press beep (lowest).
// An hourly chime sounds N beeps at the top of hour N. Each beep is one cycle
// on and one cycle off. An alarm toggles the buzzer for up to 60 cycles,
// or until the user presses stop.
//
// Ports
//   CP         in   system clock (1 Hz); all state changes on rising edge
//   nCR        in   asynchronous active-low reset
//   tell       in   hourly-chime enable
//   Hour12     in   [7:0] BCD hour, valid 8'h01..8'h12
//   Minute     in   [7:0] BCD minute
//   Second     in   [7:0] BCD second
//   alarm_hit  in   alarm-match request
//   alarm_stop in   cancels an active alarm
//   key_beep   in   key-press beep request
//   Di         out  buzzer drive (registered)
//   Tone       out  [1:0] active source: 00 none, 01 key, 10 chime, 11 alarm
//   Busy       out  high whenever the scheduler is not idle
//   Remain     out  [3:0] chime beeps still to sound after the current one
module chime_scheduler (
    input  logic       CP,
    input  logic       nCR,
    input  logic       tell,
    input  logic [7:0] Hour12,
    input  logic [7:0] Minute,
    input  logic [7:0] Second,
    input  logic       alarm_hit,
    input  logic       alarm_stop,
    input  logic       key_beep,
    output logic       Di,
    output logic [1:0] Tone,
    output logic       Busy,
    output logic [3:0] Remain
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_KEY       = 3'd1,
        ST_CHIME_ON  = 3'd2,
        ST_CHIME_OFF = 3'd3,
        ST_ALARM     = 3'd4
    } state_t;

    localparam logic [1:0] TONE_NONE  = 2'b00;
    localparam logic [1:0] TONE_KEY   = 2'b01;
    localparam logic [1:0] TONE_CHIME = 2'b10;
    localparam logic [1:0] TONE_ALARM = 2'b11;

    localparam logic [5:0] ALARM_LEN = 6'd59;

    state_t     state_r;
    logic       di_r;
    logic [1:0] tone_r;
    logic [3:0] remain_r;
    logic [5:0] alarm_cnt_r;

    logic       trigger_s;
    logic [3:0] chime_n_s;

    // A BCD hour is valid only if both nibbles are decimal digits and the value is 01..12.
    function automatic logic hour_valid(input logic [7:0] h);
        logic v;
        v = 1'b0;
        if (h[7:4] == 4'd0) begin
            v = (h[3:0] >= 4'd1) && (h[3:0] <= 4'd9);
        end else if (h[7:4] == 4'd1) begin
            v = (h[3:0] <= 4'd2);
        end else begin
            v = 1'b0;
        end
        return v;
    endfunction

    // Convert a BCD hour to binary. The tens digit is only 0 or 1 when the hour is valid.
    function automatic logic [3:0] hour_to_bin(input logic [7:0] h);
        logic [3:0] b;
        if (h[4]) begin
            b = h[3:0] + 4'd10;
        end else begin
            b = h[3:0];
        end
        return b;
    endfunction

    // Top-of-hour chime request decode and beep count.
    always_comb begin
        trigger_s = tell && (Minute == 8'h00) && (Second == 8'h00) && hour_valid(Hour12);
        chime_n_s = hour_to_bin(Hour12);
    end

    // Scheduler FSM. Each edge sets Di and Tone for the state being entered.
    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            state_r     <= ST_IDLE;
            di_r        <= 1'b0;
            tone_r      <= TONE_NONE;
            remain_r    <= 4'd0;
            alarm_cnt_r <= 6'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (alarm_hit) begin
                        state_r     <= ST_ALARM;
                        di_r        <= 1'b1;
                        tone_r      <= TONE_ALARM;
                        alarm_cnt_r <= ALARM_LEN;
                        remain_r    <= 4'd0;
                    end else if (trigger_s) begin
                        state_r  <= ST_CHIME_ON;
                        di_r     <= 1'b1;
                        tone_r   <= TONE_CHIME;
                        remain_r <= chime_n_s - 4'd1;
                    end else if (key_beep) begin
                        state_r <= ST_KEY;
                        di_r    <= 1'b1;
                        tone_r  <= TONE_KEY;
                    end else begin
                        state_r <= ST_IDLE;
                        di_r    <= 1'b0;
                        tone_r  <= TONE_NONE;
                    end
                end
                // Key and chime states can be pre-empted by an alarm. The alarm discards any beeps still owed.
                ST_KEY, ST_CHIME_ON, ST_CHIME_OFF: begin
                    if (alarm_hit) begin
                        state_r     <= ST_ALARM;
                        di_r        <= 1'b1;
                        tone_r      <= TONE_ALARM;
                        alarm_cnt_r <= ALARM_LEN;
                        remain_r    <= 4'd0;
                    end else if (state_r == ST_CHIME_ON) begin
                        state_r <= ST_CHIME_OFF;
                        di_r    <= 1'b0;
                        tone_r  <= TONE_CHIME;
                    end else if ((state_r == ST_CHIME_OFF) && (remain_r != 4'd0)) begin
                        state_r  <= ST_CHIME_ON;
                        di_r     <= 1'b1;
                        tone_r   <= TONE_CHIME;
                        remain_r <= remain_r - 4'd1;
                    end else begin
                        state_r <= ST_IDLE;
                        di_r    <= 1'b0;
                        tone_r  <= TONE_NONE;
                    end
                end
                // The alarm runs counter values 59..0, which is 60 cycles. A new alarm_hit does not restart it.
                ST_ALARM: begin
                    if (alarm_stop || (alarm_cnt_r == 6'd0)) begin
                        state_r     <= ST_IDLE;
                        di_r        <= 1'b0;
                        tone_r      <= TONE_NONE;
                        alarm_cnt_r <= 6'd0;
                    end else begin
                        state_r     <= ST_ALARM;
                        di_r        <= ~di_r;
                        tone_r      <= TONE_ALARM;
                        alarm_cnt_r <= alarm_cnt_r - 6'd1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    di_r        <= 1'b0;
                    tone_r      <= TONE_NONE;
                    remain_r    <= 4'd0;
                    alarm_cnt_r <= 6'd0;
                end
            endcase
        end
    end

    assign Di     = di_r;
    assign Tone   = tone_r;
    assign Busy   = (state_r != ST_IDLE);
    assign Remain = remain_r;

endmodule

// File: tb/tb_chime_scheduler.sv
// Directed self-checking bench for chime_scheduler.
module tb_chime_scheduler;

    logic       CP;
    logic       nCR;
    logic       tell;
    logic [7:0] Hour12;
    logic [7:0] Minute;
    logic [7:0] Second;
    logic       alarm_hit;
    logic       alarm_stop;
    logic       key_beep;
    logic       Di;
    logic [1:0] Tone;
    logic       Busy;
    logic [3:0] Remain;

    int total;
    int bad;
    int ones;

    chime_scheduler dut (
        .CP        (CP),
        .nCR       (nCR),
        .tell      (tell),
        .Hour12    (Hour12),
        .Minute    (Minute),
        .Second    (Second),
        .alarm_hit (alarm_hit),
        .alarm_stop(alarm_stop),
        .key_beep  (key_beep),
        .Di        (Di),
        .Tone      (Tone),
        .Busy      (Busy),
        .Remain    (Remain)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic step();
        @(posedge CP);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic d, input logic [1:0] t,
                             input logic b, input logic [3:0] r);
        chk({tag, ".Di"}, {7'd0, Di}, {7'd0, d});
        chk({tag, ".Tone"}, {6'd0, Tone}, {6'd0, t});
        chk({tag, ".Busy"}, {7'd0, Busy}, {7'd0, b});
        chk({tag, ".Remain"}, {4'd0, Remain}, {4'd0, r});
    endtask

    task automatic set_top(input logic [7:0] h);
        Hour12 = h;
        Minute = 8'h00;
        Second = 8'h00;
    endtask

    task automatic clear_top();
        Minute = 8'h00;
        Second = 8'h07;
    endtask

    initial begin
        logic [5:0] di_pat;
        logic [5:0] rem_pat [6];
        total = 0;
        bad   = 0;
        nCR = 1'b0; tell = 1'b0; Hour12 = 8'h01; Minute = 8'h30; Second = 8'h15;
        alarm_hit = 1'b0; alarm_stop = 1'b0; key_beep = 1'b0;
        #2;
        chk_state("reset", 1'b0, 2'b00, 1'b0, 4'd0);
        @(negedge CP);
        nCR = 1'b1;
        step();
        chk_state("idle_after_reset", 1'b0, 2'b00, 1'b0, 4'd0);

        // Three o'clock: 1,0,1,0,1,0 with Remain 2,2,1,1,0,0.
        tell = 1'b1;
        set_top(8'h03);
        di_pat = 6'b010101;
        rem_pat = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0};
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 0) clear_top();
            chk_state($sformatf("chime3_c%0d", i), di_pat[i], 2'b10, 1'b1, rem_pat[i][3:0]);
        end
        step();
        chk_state("chime3_end", 1'b0, 2'b00, 1'b0, 4'd0);

        // Twelve o'clock: 12 beeps over 24 cycles.
        set_top(8'h12);
        ones = 0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (i == 0) begin
                clear_top();
                chk("chime12_first_remain", {4'd0, Remain}, 8'd11);
            end
            if (Di) ones++;
            chk($sformatf("chime12_busy_c%0d", i), {7'd0, Busy}, 8'd1);
        end
        chk("chime12_beeps", ones[7:0], 8'd12);
        step();
        chk_state("chime12_end", 1'b0, 2'b00, 1'b0, 4'd0);

        // Invalid hours and disabled chime are silent.
        set_top(8'h13);
        step();
        chk_state("hour13", 1'b0, 2'b00, 1'b0, 4'd0);
        set_top(8'h0A);
        step();
        chk_state("hour0A", 1'b0, 2'b00, 1'b0, 4'd0);
        set_top(8'h00);
        step();
        chk_state("hour00", 1'b0, 2'b00, 1'b0, 4'd0);
        tell = 1'b0;
        set_top(8'h03);
        step();
        chk_state("tell0", 1'b0, 2'b00, 1'b0, 4'd0);
        clear_top();
        tell = 1'b1;

        // Full alarm: 60 cycles starting with 1. A repeat alarm_hit mid-way must not restart it.
        alarm_hit = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            alarm_hit = (i == 19);
            chk($sformatf("alarm_di_c%0d", i), {7'd0, Di}, (i % 2 == 0) ? 8'd1 : 8'd0);
            chk($sformatf("alarm_tone_c%0d", i), {6'd0, Tone}, 8'd3);
        end
        step();
        chk_state("alarm_end", 1'b0, 2'b00, 1'b0, 4'd0);

        // Alarm stopped during its 10th cycle.
        alarm_hit = 1'b1;
        step();
        alarm_hit = 1'b0;
        for (int i = 1; i < 10; i++) step();
        chk("alarm10_still_on", {7'd0, Busy}, 8'd1);
        alarm_stop = 1'b1;
        step();
        chk_state("alarm_stopped", 1'b0, 2'b00, 1'b0, 4'd0);
        step();
        chk_state("stop_in_idle", 1'b0, 2'b00, 1'b0, 4'd0);
        alarm_stop = 1'b0;

        // Alarm during the 2nd beep of a five o'clock chime.
        set_top(8'h05);
        step();
        clear_top();
        chk_state("chime5_b1", 1'b1, 2'b10, 1'b1, 4'd4);
        step();
        step();
        chk_state("chime5_b2", 1'b1, 2'b10, 1'b1, 4'd3);
        alarm_hit = 1'b1;
        step();
        alarm_hit = 1'b0;
        chk_state("chime5_to_alarm", 1'b1, 2'b11, 1'b1, 4'd0);
        alarm_stop = 1'b1;
        step();
        alarm_stop = 1'b0;
        chk_state("chime5_alarm_stop", 1'b0, 2'b00, 1'b0, 4'd0);
        step();
        step();
        chk_state("chime5_no_resume", 1'b0, 2'b00, 1'b0, 4'd0);

        // Key beep: one cycle of Di=1 and Tone=01.
        key_beep = 1'b1;
        step();
        key_beep = 1'b0;
        chk_state("key", 1'b1, 2'b01, 1'b1, 4'd0);
        step();
        chk_state("key_end", 1'b0, 2'b00, 1'b0, 4'd0);

        // Key beep during a two o'clock chime is dropped.
        set_top(8'h02);
        step();
        clear_top();
        key_beep = 1'b1;
        step();
        chk_state("key_in_chime_off", 1'b0, 2'b10, 1'b1, 4'd1);
        step();
        key_beep = 1'b0;
        chk_state("key_in_chime_on", 1'b1, 2'b10, 1'b1, 4'd0);
        step();
        step();
        chk_state("key_in_chime_end", 1'b0, 2'b00, 1'b0, 4'd0);

        // A key beep arriving with the chime trigger loses to the chime.
        set_top(8'h01);
        key_beep = 1'b1;
        step();
        key_beep = 1'b0;
        clear_top();
        chk_state("key_vs_chime", 1'b1, 2'b10, 1'b1, 4'd0);
        step();
        step();
        chk_state("key_vs_chime_end", 1'b0, 2'b00, 1'b0, 4'd0);

        // Reset pulse between edges during an alarm.
        alarm_hit = 1'b1;
        step();
        alarm_hit = 1'b0;
        step();
        #2;
        nCR = 1'b0;
        #1;
        chk_state("alarm_reset", 1'b0, 2'b00, 1'b0, 4'd0);
        #1;
        nCR = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state($sformatf("after_reset_c%0d", i), 1'b0, 2'b00, 1'b0, 4'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
